// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the pipelined mux tree.
package mux_pkg;

    // Select-source encoding for the mode input.
    localparam logic MODE_SEL  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // Ceiling log2 for tools without $clog2. The tree depth LEVELS is the
    // select width, so one register stage exists per bit of the channel index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of nodes entering tree level k for an n-leaf tree: ceil(n / 2^k).
    function automatic int level_width(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: ceil(N_IN/2) 2:1 muxes steered by idx bit LEVEL,
// registered together with the beat's valid, index and error sideband.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3,
    parameter int LEVEL = 0,
    localparam int N_OUT = level_width(N_IN, 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv_i,
    input  logic                   valid_i,
    input  logic [N_IN*WIDTH-1:0]  data_i,
    input  logic [SEL_W-1:0]       idx_i,
    input  logic                   err_i,
    output logic                   valid_o,
    output logic [N_OUT*WIDTH-1:0] data_o,
    output logic [SEL_W-1:0]       idx_o,
    output logic                   err_o
);

    logic                   sel_bit;
    logic [N_OUT*WIDTH-1:0] data_d;
    logic [N_OUT*WIDTH-1:0] data_q;
    logic [SEL_W-1:0]       idx_q;
    logic                   valid_q;
    logic                   err_q;

    assign sel_bit = idx_i[LEVEL];

    // Pair nodes (2j, 2j+1); an unpaired last node faces a zero leaf.
    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_full
            assign data_d[j*WIDTH +: WIDTH] = sel_bit ? data_i[(2*j+1)*WIDTH +: WIDTH]
                                                      : data_i[(2*j)*WIDTH +: WIDTH];
        end else begin : g_odd
            assign data_d[j*WIDTH +: WIDTH] = sel_bit ? {WIDTH{1'b0}}
                                                      : data_i[(2*j)*WIDTH +: WIDTH];
        end
    end

    // Capture this level's result; every stage advances in lockstep on adv_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset as well so the final stage reads 0 out of reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else if (adv_i) begin
            // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
            valid_q <= valid_i;
            data_q  <= data_d;
            idx_q   <= idx_i;
            err_q   <= err_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_CH:1 mux tree with valid/ready handshake, global stall and an
// optional round-robin scan counter as the select source.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 8,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int LEVELS = SEL_W;

    logic             adv;
    logic             accept;
    logic [SEL_W-1:0] idx;
    logic             beat_err;
    logic [SEL_W-1:0] scan_d;
    logic [SEL_W-1:0] scan_q;
    logic             last_valid;
    logic [WIDTH-1:0] last_data;
    logic [SEL_W-1:0] last_idx;
    logic             last_err;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign adv      = !last_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // The index is fixed at accept time and rides with the beat through the tree.
    assign idx      = (mode == MODE_SCAN) ? scan_q : sel;
    assign beat_err = 32'(idx) >= N_CH;

    // Next scan value: step on an accepted scan-mode beat, wrapping at N_CH-1.
    always_comb begin
        // NOTE: default assignment first so no path leaves scan_d unassigned (no latch).
        scan_d = scan_q;
        if (accept && mode == MODE_SCAN) begin
            scan_d = (scan_q == SEL_W'(N_CH - 1)) ? '0 : scan_q + 1'b1;
        end
    end

    // Scan counter register; holds across stalls and while in select mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    // One registered 2:1 level per select bit, chained from the channel inputs.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_IN  = level_width(N_CH, k);
        localparam int N_OUT = level_width(N_CH, k + 1);

        logic                   v_in;
        logic [N_IN*WIDTH-1:0]  d_in;
        logic [SEL_W-1:0]       idx_in;
        logic                   err_in;
        logic                   v_out;
        logic [N_OUT*WIDTH-1:0] d_out;
        logic [SEL_W-1:0]       idx_out;
        logic                   err_out;

        if (k == 0) begin : g_head
            assign v_in   = in_valid;
            assign d_in   = in_data;
            assign idx_in = idx;
            assign err_in = beat_err;
        end else begin : g_link
            assign v_in   = g_lvl[k-1].v_out;
            assign d_in   = g_lvl[k-1].d_out;
            assign idx_in = g_lvl[k-1].idx_out;
            assign err_in = g_lvl[k-1].err_out;
        end

        mux_tree_stage #(
            .WIDTH (WIDTH),
            .N_IN  (N_IN),
            .SEL_W (SEL_W),
            .LEVEL (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (adv),
            .valid_i (v_in),
            .data_i  (d_in),
            .idx_i   (idx_in),
            .err_i   (err_in),
            .valid_o (v_out),
            .data_o  (d_out),
            .idx_o   (idx_out),
            .err_o   (err_out)
        );
    end

    assign last_valid = g_lvl[LEVELS-1].v_out;
    assign last_data  = g_lvl[LEVELS-1].d_out;
    assign last_idx   = g_lvl[LEVELS-1].idx_out;
    assign last_err   = g_lvl[LEVELS-1].err_out;

    // An out-of-range index never leaks channel data.
    assign out_valid = last_valid;
    assign out_data  = last_err ? '0 : last_data;
    assign out_ch    = last_idx;
    assign out_err   = last_err;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench: scoreboard on an 8-channel build, vector table on a 5-channel build.
module tb_mux_tree_pipe;

    localparam int W  = 8;
    localparam int N8 = 8;
    localparam int N5 = 5;
    localparam int S  = 3;

    typedef struct packed {
        logic [W-1:0] data;
        logic [S-1:0] ch;
        logic         err;
    } beat_t;

    typedef struct packed {
        logic [S-1:0] sel;
        logic [W-1:0] data;
        logic         err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            mode;
    logic [S-1:0]    sel;
    logic [N8*W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_data;
    logic [S-1:0]    out_ch;
    logic            out_err;
    logic            out_valid;
    logic            out_ready;

    logic            mode5;
    logic [S-1:0]    sel5;
    logic [N5*W-1:0] in_data5;
    logic [N5*W-1:0] base5;
    logic            in_valid5;
    logic            in_ready5;
    logic [W-1:0]    out_data5;
    logic [S-1:0]    out_ch5;
    logic            out_err5;
    logic            out_valid5;
    logic            out_ready5;

    mux_tree_pipe #(.WIDTH(W), .N_CH(N8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_tree_pipe #(.WIDTH(W), .N_CH(N5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_data(in_data5),
        .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
        .out_ch(out_ch5), .out_err(out_err5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t q8[$];
    int    scan_m   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one beat: pick channel idx, or flag it out of range.
    function automatic beat_t model(input logic [N8*W-1:0] d, input int n, input int idx);
        beat_t b;
        b.ch   = idx[S-1:0];
        b.err  = (idx >= n);
        b.data = b.err ? '0 : d[idx*W +: W];
        return b;
    endfunction

    // Scoreboard for the 8-channel build: push on accept, pop on output handshake.
    always @(negedge clk) begin : mon8
        beat_t e;
        int    idx;
        if (rst) begin
            q8.delete();
            scan_m = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected output beat", 32'(out_ch), 32'hFFFF_FFFF);
                end else begin
                    e = q8.pop_front();
                    check("sb out_data", 32'(out_data), 32'(e.data));
                    check("sb out_ch", 32'(out_ch), 32'(e.ch));
                    check("sb out_err", 32'(out_err), 32'(e.err));
                end
            end
            if (in_valid && in_ready) begin
                idx = mode ? scan_m : int'(sel);
                q8.push_back(model(in_data, N8, idx));
                if (mode) scan_m = (scan_m == N8 - 1) ? 0 : scan_m + 1;
            end
        end
    end

    // Present one beat on the 8-channel build and hold it until accepted.
    task automatic send(input int s, input logic m);
        int   guard;
        logic acc;
        guard    = 0;
        mode     = m;
        sel      = s[S-1:0];
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("send accepted", 32'(acc), 1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q8.size() != 0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("scoreboard drained", q8.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tab[6];
        int   lat;
        int   run;
        int   w;
        int   bad;

        tab[0] = '{sel: 3'd6, data: 8'h00, err: 1'b1};
        tab[1] = '{sel: 3'd4, data: 8'h44, err: 1'b0};
        tab[2] = '{sel: 3'd0, data: 8'h00, err: 1'b0};
        tab[3] = '{sel: 3'd5, data: 8'h00, err: 1'b1};
        tab[4] = '{sel: 3'd7, data: 8'h00, err: 1'b1};
        tab[5] = '{sel: 3'd3, data: 8'h33, err: 1'b0};

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 1'b0; out_ready = 1'b1;
        mode5 = 1'b0; sel5 = '0; in_valid5 = 1'b0; out_ready5 = 1'b1;
        for (int c = 0; c < N8; c++) in_data[c*W +: W] = 8'(c * 8'h11);
        for (int c = 0; c < N5; c++) base5[c*W +: W] = 8'(c * 8'h11);
        in_data5 = base5;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_data", 32'(out_data), 0);
        check("rst out_ch", 32'(out_ch), 0);
        check("rst out_err", 32'(out_err), 0);
        check("rst in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single beat latency, sel=5
        send(5, 1'b0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        check("latency out_data", 32'(out_data), 32'h55);
        check("latency out_ch", 32'(out_ch), 5);
        @(posedge clk);
        #1;

        // Streaming sel=0..7 back to back
        fork
            begin
                for (int s = 0; s < 8; s++) begin
                    send(s, 1'b0);
                    check("stream in_ready", 32'(in_ready), 1);
                end
                in_valid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                run = 0;
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                check("stream run length", run, 8);
            end
        join
        drain();

        // Backpressure: out_ready low for 4 cycles mid-stream
        fork
            begin
                for (int s = 0; s < 12; s++) send((s * 3) % 8, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall in_ready", 32'(in_ready), 0);
                    check("stall out_valid", 32'(out_valid), 1);
                    if (q8.size() > 0) check("stall held data", 32'(out_data), 32'(q8[0].data));
                    else check("stall queue populated", q8.size(), 1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Scan mode: 10 beats, then a 2-cycle stall, then mode mixing
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 7)), 1'b1);
        fork
            begin
                for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 7)), 1'b1);
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        send(6, 1'b0);
        send(6, 1'b0);
        send(0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Five-channel build: vector table
        for (int i = 0; i < 6; i++) begin
            sel5 = tab[i].sel;
            in_valid5 = 1'b1;
            @(posedge clk);
            #1 in_valid5 = 1'b0;
            in_data5 = ~base5;
            w = 0;
            while (!out_valid5 && w < 10) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("n5 latency", w, 2);
            check("n5 out_data", 32'(out_data5), 32'(tab[i].data));
            check("n5 out_err", 32'(out_err5), 32'(tab[i].err));
            check("n5 out_ch", 32'(out_ch5), 32'(tab[i].sel));
            in_data5 = base5;
            @(posedge clk);
            #1;
        end

        // Mid-flight reset with 3 scan beats in the pipe
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b1);
        check("pre-reset out_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("post-reset out_valid", 32'(out_valid), 0);
        check("post-reset out_data", 32'(out_data), 0);
        check("post-reset in_ready", 32'(in_ready), 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("discarded beats", bad, 0);
        send(3, 1'b1);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("scan restart ch", 32'(out_ch), 0);
        check("scan restart data", 32'(out_data), 32'h00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
